rob_multi_commit: RTL

ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

---
 rtl/rob_multi_commit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rob_multi_commit.sv
// Reorder buffer with CDB writeback, operand query bypass and up to two in-order retirements per cycle.
// Latency: alloc/CDB update state on the edge; an entry completed at edge N may retire in cycle N+1.
// Backpressure: alloc_ready drops when full; rdy_in low freezes all state and masks commit/flush outputs.
module rob_multi_commit #(
   parameter int DEPTH     = 32,
   parameter int CDB_PORTS = 2,
   parameter int COMMIT_W  = 2,
   localparam int IDW      = $clog2(DEPTH)
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic                      rdy_in,
   input  logic                      alloc_valid,
   input  logic [6:0]                alloc_type,
   input  logic [31:0]               alloc_pc,
   input  logic [4:0]                alloc_rd,
   input  logic [31:0]               alloc_value,
   input  logic [31:0]               alloc_imm,
   input  logic                      alloc_rvc,
   output logic                      alloc_ready,
   output logic [IDW-1:0]            alloc_id,
   input  logic [CDB_PORTS-1:0]      cdb_valid,
   input  logic [CDB_PORTS*IDW-1:0]  cdb_id,
   input  logic [CDB_PORTS*32-1:0]   cdb_value,
   input  logic [IDW-1:0]            qry_id_a,
   input  logic [IDW-1:0]            qry_id_b,
   output logic                      qry_done_a,
   output logic                      qry_done_b,
   output logic [31:0]               qry_value_a,
   output logic [31:0]               qry_value_b,
   output logic [COMMIT_W-1:0]       cmt_valid,
   output logic [COMMIT_W-1:0]       cmt_has_rd,
   output logic [COMMIT_W*5-1:0]     cmt_rd,
   output logic [COMMIT_W*32-1:0]    cmt_value,
   output logic [COMMIT_W*IDW-1:0]   cmt_id,
   output logic                      store_go,
   output logic                      flush,
   output logic                      redirect,
   output logic [31:0]               redirect_pc,
   output logic [IDW:0]              count
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [IDW:0] DEPTH_C = (IDW+1)'(DEPTH);

   logic [6:0]       e_type  [DEPTH];
   logic [31:0]      e_pc    [DEPTH];
   logic [4:0]       e_rd    [DEPTH];
   logic [31:0]      e_value [DEPTH];
   logic [31:0]      e_imm   [DEPTH];
   logic             e_rvc   [DEPTH];
   logic [DEPTH-1:0] e_busy;
   logic [DEPTH-1:0] e_done;
   logic [IDW-1:0]   head, tail;
   logic [IDW:0]     cnt;

   logic             en, alloc_acc, mispred, flush_int;
   logic             br0, jalr0, st0;
   logic [IDW-1:0]   h0, h1;
   logic [1:0]       s_valid, s_has_rd;
   logic [9:0]       s_rd;
   logic [63:0]      s_val;
   logic [2*IDW-1:0] s_id;
   logic [IDW:0]     n_cmt;
   logic             qa_hit, qb_hit;
   logic [31:0]      qa_val, qb_val;

   function automatic logic writes_rd(input logic [6:0] t, input logic [4:0] rd);
      logic ok;
      case (t)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
         7'b1100111, 7'b0010111, 7'b0110111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok && (rd != 5'd0);
   endfunction

   // Commit selection, misprediction detection and redirect target from registered state.
   always_comb begin
      en        = rdy_in && !rst_in;
      alloc_acc = alloc_valid && (cnt < DEPTH_C);
      h0        = head;
      h1        = head + IDW'(1);
      br0       = (e_type[h0] == OP_BRANCH);
      jalr0     = (e_type[h0] == OP_JALR);
      st0       = (e_type[h0] == OP_STORE);
      s_valid   = 2'b00;
      s_valid[0] = en && e_busy[h0] && e_done[h0];
      s_valid[1] = (COMMIT_W == 2) && s_valid[0] && e_busy[h1] && e_done[h1] && !(br0 || jalr0 || st0);
      mispred   = s_valid[0] && br0 && (e_rd[h0][0] != e_value[h0][0]);
      flush_int = mispred || (s_valid[0] && jalr0);
      n_cmt     = (IDW+1)'(s_valid[0]) + (IDW+1)'(s_valid[1]);
      s_has_rd  = {writes_rd(e_type[h1], e_rd[h1]), writes_rd(e_type[h0], e_rd[h0])};
      s_rd      = {e_rd[h1], e_rd[h0]};
      s_val     = {e_value[h1], e_value[h0]};
      s_id      = {h1, h0};
      redirect_pc = 32'd0;
      if (s_valid[0] && jalr0)
         redirect_pc = e_imm[h0];
      else if (mispred)
         redirect_pc = e_value[h0][0] ? (e_pc[h0] + e_imm[h0])
                                      : (e_pc[h0] + (e_rvc[h0] ? 32'd2 : 32'd4));
   end

   assign cmt_valid   = s_valid[COMMIT_W-1:0];
   assign cmt_has_rd  = s_has_rd[COMMIT_W-1:0];
   assign cmt_rd      = s_rd[COMMIT_W*5-1:0];
   assign cmt_value   = s_val[COMMIT_W*32-1:0];
   assign cmt_id      = s_id[COMMIT_W*IDW-1:0];
   assign store_go    = s_valid[0] && st0;
   assign flush       = flush_int;
   assign redirect    = flush_int;
   assign alloc_ready = rst_in || (cnt < DEPTH_C);
   assign alloc_id    = rst_in ? '0 : tail;
   assign count       = cnt;

   // Operand lookup with same-cycle CDB bypass; scanning high-to-low lets port 0 win.
   always_comb begin
      qa_hit = 1'b0; qa_val = 32'd0;
      qb_hit = 1'b0; qb_val = 32'd0;
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
         if (cdb_valid[p] && cdb_id[p*IDW +: IDW] == qry_id_a) begin
            qa_hit = 1'b1; qa_val = cdb_value[p*32 +: 32];
         end
         if (cdb_valid[p] && cdb_id[p*IDW +: IDW] == qry_id_b) begin
            qb_hit = 1'b1; qb_val = cdb_value[p*32 +: 32];
         end
      end
      qry_done_a  = !rst_in && (qa_hit || (e_busy[qry_id_a] && e_done[qry_id_a]));
      qry_done_b  = !rst_in && (qb_hit || (e_busy[qry_id_b] && e_done[qry_id_b]));
      qry_value_a = !qry_done_a ? 32'd0 : (qa_hit ? qa_val : e_value[qry_id_a]);
      qry_value_b = !qry_done_b ? 32'd0 : (qb_hit ? qb_val : e_value[qry_id_b]);
   end

   // Buffer state: reset, flush, then CDB completion, retirement and dispatch in that order.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         e_busy <= '0;
         e_done <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_type[i]  <= '0;
            e_pc[i]    <= '0;
            e_rd[i]    <= '0;
            e_value[i] <= '0;
            e_imm[i]   <= '0;
            e_rvc[i]   <= 1'b0;
         end
      end else if (rdy_in) begin
         if (flush_int) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            e_busy <= '0;
            e_done <= '0;
         end else begin
            for (int p = CDB_PORTS-1; p >= 0; p--) begin
               if (cdb_valid[p] && e_busy[cdb_id[p*IDW +: IDW]]) begin
                  e_done[cdb_id[p*IDW +: IDW]] <= 1'b1;
                  if (e_type[cdb_id[p*IDW +: IDW]] == OP_JALR)
                     e_imm[cdb_id[p*IDW +: IDW]] <= cdb_value[p*32 +: 32];
                  else
                     e_value[cdb_id[p*IDW +: IDW]] <= cdb_value[p*32 +: 32];
               end
            end
            if (s_valid[0]) begin
               e_busy[h0] <= 1'b0;
               e_done[h0] <= 1'b0;
            end
            if (s_valid[1]) begin
               e_busy[h1] <= 1'b0;
               e_done[h1] <= 1'b0;
            end
            if (alloc_acc) begin
               e_type[tail]  <= alloc_type;
               e_pc[tail]    <= alloc_pc;
               e_rd[tail]    <= alloc_rd;
               e_value[tail] <= alloc_value;
               e_imm[tail]   <= alloc_imm;
               e_rvc[tail]   <= alloc_rvc;
               e_busy[tail]  <= 1'b1;
               e_done[tail]  <= (alloc_type == OP_LUI);
            end
            head <= head + n_cmt[IDW-1:0];
            tail <= tail + IDW'(alloc_acc);
            cnt  <= cnt + (IDW+1)'(alloc_acc) - n_cmt;
         end
      end
   end

endmodule
